// File: rtl/hsid_x_pkg.sv
// Shared types and constants for the HSpecID-X sequencer and its min/max tracker.
package hsid_x_pkg;

  localparam int WORD_BYTES    = 4;
  localparam int MSE_WIDTH     = 32;
  localparam int LIB_REF_WIDTH = 8;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RD_CAP,
    ST_WAIT_CAP,
    ST_RD_LIB,
    ST_WAIT_LIB,
    ST_PUSH,
    ST_WAIT_MSE,
    ST_DONE,
    ST_ERROR
  } hsid_x_seq_state_e;

  // "ref" is a reserved word, so the library index field is lib_ref.
  typedef struct packed {
    logic [MSE_WIDTH-1:0]     value;
    logic [LIB_REF_WIDTH-1:0] lib_ref;
  } hsid_x_mse_res_t;

endpackage

// File: rtl/hsid_x_minmax.sv
// Min/max MSE tracker: first result loads both, later results replace only on a
// strict unsigned improvement so ties keep the earliest library index.
module hsid_x_minmax
  import hsid_x_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            i_clear,
  input  logic            i_load,
  input  logic            i_update,
  input  hsid_x_mse_res_t i_res,
  output hsid_x_mse_res_t o_min,
  output hsid_x_mse_res_t o_max
);

  hsid_x_mse_res_t r_min;
  hsid_x_mse_res_t r_max;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_min <= '0;
      r_max <= '0;
    end else if (i_load) begin
      r_min <= i_res;
      r_max <= i_res;
    end else if (i_update) begin
      if (i_res.value < r_min.value) r_min <= i_res;
      if (i_res.value > r_max.value) r_max <= i_res;
    end
  end

  assign o_min = r_min;
  assign o_max = r_max;

endmodule

// File: rtl/hsid_x_seq.sv
// HSpecID-X top sequencer: walks captured vs library pixel bands over a
// single-outstanding read port, streams band pairs to the MSE unit, tracks min/max.
module hsid_x_seq
  import hsid_x_pkg::*;
#(
  parameter  int WORD_WIDTH            = 32,
  parameter  int HSI_BANDS             = 128,
  parameter  int HSI_LIBRARY_SIZE      = 256,
  localparam int HSI_BANDS_ADDR        = $clog2(HSI_BANDS),
  localparam int HSI_LIBRARY_SIZE_ADDR = $clog2(HSI_LIBRARY_SIZE)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             clear,
  input  logic [HSI_LIBRARY_SIZE_ADDR-1:0] library_size,
  input  logic [HSI_BANDS_ADDR-1:0]        pixel_bands,
  input  logic [WORD_WIDTH-1:0]            captured_pixel_addr,
  input  logic [WORD_WIDTH-1:0]            library_pixel_addr,
  output logic                             idle,
  output logic                             ready,
  output logic                             done,
  output logic                             error,
  output logic                             mem_req,
  output logic [WORD_WIDTH-1:0]            mem_addr,
  input  logic                             mem_gnt,
  input  logic                             mem_rvalid,
  input  logic [WORD_WIDTH-1:0]            mem_rdata,
  input  logic                             mem_err,
  output logic                             band_valid,
  output logic [WORD_WIDTH-1:0]            band_cap,
  output logic [WORD_WIDTH-1:0]            band_lib,
  output logic                             band_last,
  input  logic                             mse_valid,
  input  logic [WORD_WIDTH-1:0]            mse_value,
  output logic [HSI_LIBRARY_SIZE_ADDR-1:0] mse_min_ref,
  output logic [HSI_LIBRARY_SIZE_ADDR-1:0] mse_max_ref,
  output logic [WORD_WIDTH-1:0]            mse_min_value,
  output logic [WORD_WIDTH-1:0]            mse_max_value
);

  hsid_x_seq_state_e r_state, w_next;

  logic [HSI_BANDS_ADDR-1:0]        r_b, r_bands;
  logic [HSI_LIBRARY_SIZE_ADDR-1:0] r_p, r_lib_size;
  logic [WORD_WIDTH-1:0]            r_cap_base, r_lib_addr, r_cap_word, r_lib_word;
  logic                             r_stale;

  logic w_start_ok, w_mm_load, w_mm_update, w_last_band, w_last_pix, w_in_wait;
  logic [WORD_WIDTH-1:0] w_band_off;
  hsid_x_mse_res_t w_res, w_min, w_max;

  assign w_last_band = (r_b == r_bands - HSI_BANDS_ADDR'(1));
  assign w_last_pix  = (r_p == r_lib_size - HSI_LIBRARY_SIZE_ADDR'(1));
  assign w_in_wait   = (r_state == ST_WAIT_CAP) || (r_state == ST_WAIT_LIB);
  assign w_band_off  = WORD_WIDTH'(r_b) * WORD_WIDTH'(WORD_BYTES);

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    w_next      = r_state;
    mem_req     = 1'b0;
    mem_addr    = '0;
    band_valid  = 1'b0;
    band_last   = 1'b0;
    w_start_ok  = 1'b0;
    w_mm_load   = 1'b0;
    w_mm_update = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          if (library_size == '0 || pixel_bands == '0) begin
            w_next = ST_ERROR;
          end else begin
            w_next     = ST_RD_CAP;
            w_start_ok = 1'b1;
          end
        end
      end
      ST_RD_CAP: begin
        // A read orphaned by clear must drain before the next request goes out.
        mem_req  = !r_stale;
        mem_addr = r_cap_base + w_band_off;
        if (mem_req && mem_gnt) w_next = ST_WAIT_CAP;
      end
      ST_WAIT_CAP: if (mem_rvalid) w_next = mem_err ? ST_ERROR : ST_RD_LIB;
      ST_RD_LIB: begin
        mem_req  = !r_stale;
        mem_addr = r_lib_addr;
        if (mem_req && mem_gnt) w_next = ST_WAIT_LIB;
      end
      ST_WAIT_LIB: if (mem_rvalid) w_next = mem_err ? ST_ERROR : ST_PUSH;
      ST_PUSH: begin
        band_valid = 1'b1;
        band_last  = w_last_band;
        w_next     = w_last_band ? ST_WAIT_MSE : ST_RD_CAP;
      end
      ST_WAIT_MSE: begin
        if (mse_valid) begin
          w_mm_load   = (r_p == '0);
          w_mm_update = (r_p != '0);
          w_next      = w_last_pix ? ST_DONE : ST_RD_CAP;
        end
      end
      default: w_next = ST_IDLE;
    endcase
    if (clear) w_next = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_b        <= '0;
      r_bands    <= '0;
      r_p        <= '0;
      r_lib_size <= '0;
      r_cap_base <= '0;
      r_lib_addr <= '0;
      r_cap_word <= '0;
      r_lib_word <= '0;
      r_stale    <= 1'b0;
    end else begin
      if (clear && ((w_in_wait && !mem_rvalid) || (mem_req && mem_gnt))) r_stale <= 1'b1;
      else if (mem_rvalid)                                                r_stale <= 1'b0;

      if (clear) begin
        r_b <= '0;
        r_p <= '0;
      end else begin
        if (w_start_ok) begin
          r_b        <= '0;
          r_p        <= '0;
          r_bands    <= pixel_bands;
          r_lib_size <= library_size;
          r_cap_base <= captured_pixel_addr;
          r_lib_addr <= library_pixel_addr;
        end
        if (r_state == ST_WAIT_CAP && mem_rvalid && !mem_err) r_cap_word <= mem_rdata;
        if (r_state == ST_WAIT_LIB && mem_rvalid && !mem_err) begin
          r_lib_word <= mem_rdata;
          r_lib_addr <= r_lib_addr + WORD_WIDTH'(WORD_BYTES);
        end
        if (r_state == ST_PUSH) r_b <= w_last_band ? '0 : r_b + HSI_BANDS_ADDR'(1);
        if (r_state == ST_WAIT_MSE && mse_valid && !w_last_pix) r_p <= r_p + HSI_LIBRARY_SIZE_ADDR'(1);
      end
    end
  end

  assign w_res.value   = MSE_WIDTH'(mse_value);
  assign w_res.lib_ref = LIB_REF_WIDTH'(r_p);

  hsid_x_minmax u_minmax (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (clear || w_start_ok),
    .i_load   (w_mm_load),
    .i_update (w_mm_update),
    .i_res    (w_res),
    .o_min    (w_min),
    .o_max    (w_max)
  );

  assign idle          = (r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERROR);
  assign ready         = idle;
  assign done          = (r_state == ST_DONE);
  assign error         = (r_state == ST_ERROR);
  assign band_cap      = r_cap_word;
  assign band_lib      = r_lib_word;
  assign mse_min_value = WORD_WIDTH'(w_min.value);
  assign mse_max_value = WORD_WIDTH'(w_max.value);
  assign mse_min_ref   = HSI_LIBRARY_SIZE_ADDR'(w_min.lib_ref);
  assign mse_max_ref   = HSI_LIBRARY_SIZE_ADDR'(w_max.lib_ref);

endmodule

// File: tb/tb_hsid_x_seq.sv
// Directed bench for hsid_x_seq: bus/MSE responders plus a linear list of checked steps.
module tb_hsid_x_seq;

  logic        clk = 1'b0;
  logic        rst, start, clear;
  logic [7:0]  library_size;
  logic [6:0]  pixel_bands;
  logic [31:0] captured_pixel_addr, library_pixel_addr;
  logic        idle, ready, done, error;
  logic        mem_req, mem_gnt, mem_rvalid, mem_err;
  logic [31:0] mem_addr, mem_rdata;
  logic        band_valid, band_last, mse_valid;
  logic [31:0] band_cap, band_lib, mse_value;
  logic [7:0]  mse_min_ref, mse_max_ref;
  logic [31:0] mse_min_value, mse_max_value;

  int total = 0;
  int bad   = 0;

  int          stall_left = 0;
  int          err_at     = 0;
  int          rd_cnt     = 0;
  bit          pend       = 1'b0;
  logic [31:0] pend_addr  = '0;
  int          mse_cnt    = 0;
  int          mse_idx    = 0;
  logic [31:0] mse_vals [3];
  logic [31:0] addr_log [$];
  logic [31:0] cap_log  [$];
  logic [31:0] lib_log  [$];
  bit          last_log [$];

  hsid_x_seq dut (
    .clk(clk), .rst(rst), .start(start), .clear(clear),
    .library_size(library_size), .pixel_bands(pixel_bands),
    .captured_pixel_addr(captured_pixel_addr), .library_pixel_addr(library_pixel_addr),
    .idle(idle), .ready(ready), .done(done), .error(error),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_err(mem_err),
    .band_valid(band_valid), .band_cap(band_cap), .band_lib(band_lib), .band_last(band_last),
    .mse_valid(mse_valid), .mse_value(mse_value),
    .mse_min_ref(mse_min_ref), .mse_max_ref(mse_max_ref),
    .mse_min_value(mse_min_value), .mse_max_value(mse_max_value)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC3C3_0000;
  endfunction

  assign mem_gnt = mem_req && (stall_left == 0);

  // Memory and MSE responders update on the falling edge, away from DUT sampling.
  always @(negedge clk) begin
    if (mem_req && stall_left > 0) stall_left--;
    mem_rvalid = pend;
    mem_err    = pend && (rd_cnt + 1 == err_at);
    mem_rdata  = pend ? mem_word(pend_addr) : '0;
    if (pend) rd_cnt++;
    pend      = mem_req && (stall_left == 0);
    pend_addr = mem_addr;
    if (pend) addr_log.push_back(mem_addr);
    if (band_valid) begin
      cap_log.push_back(band_cap);
      lib_log.push_back(band_lib);
      last_log.push_back(band_last);
    end
    mse_valid = 1'b0;
    if (mse_cnt > 0) begin
      mse_cnt--;
      if (mse_cnt == 0) begin
        mse_valid = 1'b1;
        mse_value = mse_vals[mse_idx];
        mse_idx++;
      end
    end
    if (band_valid && band_last) mse_cnt = 2;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    addr_log.delete();
    cap_log.delete();
    lib_log.delete();
    last_log.delete();
    mse_idx = 0;
  endtask

  task automatic run_start(input logic [6:0] bands, input logic [7:0] lsz,
                           input logic [31:0] cap, input logic [31:0] lib);
    pixel_bands         = bands;
    library_size        = lsz;
    captured_pixel_addr = cap;
    library_pixel_addr  = lib;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!(done || error) && n < 500) begin
      tick();
      n++;
    end
    check({tag, "_timeout"}, 32'(n < 500), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    rst = 1'b1; start = 1'b0; clear = 1'b0;
    library_size = '0; pixel_bands = '0;
    captured_pixel_addr = '0; library_pixel_addr = '0;
    mse_vals[0] = '0; mse_vals[1] = '0; mse_vals[2] = '0;
    tick(); tick();
    rst = 1'b0;
    tick();

    // Reset state
    check("rst_idle", idle, 1);
    check("rst_ready", ready, 1);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_req", mem_req, 0);
    check("rst_bvalid", band_valid, 0);
    check("rst_min", mse_min_value, 0);
    check("rst_max", mse_max_value, 0);

    // 1: happy path, 2 bands x 3 pixels
    clear_logs();
    mse_vals[0] = 50; mse_vals[1] = 20; mse_vals[2] = 80;
    run_start(2, 3, 32'h1000, 32'h2000);
    check("t1_busy_idle", idle, 0);
    wait_done("t1");
    check("t1_done", done, 1);
    check("t1_error", error, 0);
    check("t1_nreads", addr_log.size(), 12);
    for (int i = 0; i < 12 && i < addr_log.size(); i++) begin
      if (i % 2 == 0) check($sformatf("t1_addr%0d", i), addr_log[i], 32'h1000 + 4 * ((i / 2) % 2));
      else            check($sformatf("t1_addr%0d", i), addr_log[i], 32'h2000 + 4 * (i / 2));
    end
    check("t1_nbands", cap_log.size(), 6);
    if (cap_log.size() == 6) begin
      check("t1_cap0", cap_log[0], mem_word(32'h1000));
      check("t1_lib0", lib_log[0], mem_word(32'h2000));
      check("t1_cap3", cap_log[3], mem_word(32'h1004));
      check("t1_lib3", lib_log[3], mem_word(32'h200C));
      check("t1_last0", last_log[0], 0);
      check("t1_last1", last_log[1], 1);
    end
    check("t1_min", mse_min_value, 20);
    check("t1_minref", mse_min_ref, 1);
    check("t1_max", mse_max_value, 80);
    check("t1_maxref", mse_max_ref, 2);

    // 2: ties keep the earliest index; restart from DONE clears done and min/max
    clear_logs();
    mse_vals[0] = 7; mse_vals[1] = 7; mse_vals[2] = 7;
    run_start(1, 3, 32'h1000, 32'h2000);
    check("t2_done_clr", done, 0);
    check("t2_min_clr", mse_min_value, 0);
    wait_done("t2");
    check("t2_min", mse_min_value, 7);
    check("t2_minref", mse_min_ref, 0);
    check("t2_max", mse_max_value, 7);
    check("t2_maxref", mse_max_ref, 0);

    // 3: zero configuration
    run_start(0, 3, 32'h1000, 32'h2000);
    check("t3_error", error, 1);
    check("t3_done", done, 0);
    check("t3_req", mem_req, 0);
    tick();
    check("t3_req2", mem_req, 0);
    run_start(2, 0, 32'h1000, 32'h2000);
    check("t3_error_lib0", error, 1);
    clear_logs();
    mse_vals[0] = 9;
    run_start(1, 1, 32'h1000, 32'h2000);
    check("t3_error_clr", error, 0);
    check("t3_req_run", mem_req, 1);
    wait_done("t3");
    check("t3_done_ok", done, 1);
    check("t3_min", mse_min_value, 9);

    // 4: grant stall then bus error on the third read
    clear_logs();
    stall_left = 6; rd_cnt = 0; err_at = 3;
    run_start(2, 1, 32'h3000, 32'h4000);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t4_req%0d", i), mem_req, 1);
      check($sformatf("t4_addr%0d", i), mem_addr, 32'h3000);
      tick();
    end
    wait_done("t4");
    check("t4_error", error, 1);
    check("t4_done", done, 0);
    check("t4_req_off", mem_req, 0);
    check("t4_nbands", cap_log.size(), 1);
    check("t4_nreads", addr_log.size(), 3);
    err_at = 0; stall_left = 0;

    // 5: clear at pixel 1 with a late rvalid and a simultaneous start
    clear_logs();
    mse_vals[0] = 50; mse_vals[1] = 20; mse_vals[2] = 80;
    run_start(2, 3, 32'h1000, 32'h2000);
    found = 1'b0;
    for (int n = 0; n < 200 && !found; n++) begin
      tick();
      if (mem_req && mem_addr == 32'h2008) found = 1'b1;
    end
    check("t5_reached", found, 1);
    check("t5_min_pre", mse_min_value, 50);
    tick();
    clear = 1'b1; start = 1'b1;
    tick();
    clear = 1'b0; start = 1'b0;
    check("t5_idle", idle, 1);
    check("t5_req", mem_req, 0);
    check("t5_done", done, 0);
    check("t5_error", error, 0);
    check("t5_min", mse_min_value, 0);
    check("t5_max", mse_max_value, 0);
    check("t5_nbands", cap_log.size(), 2);
    tick();
    check("t5_still_idle", idle, 1);
    check("t5_still_noreq", mem_req, 0);

    // 6: library address wraps through zero
    clear_logs();
    mse_vals[0] = 5;
    run_start(2, 1, 32'h0500, 32'hFFFF_FFFC);
    wait_done("t6");
    check("t6_done", done, 1);
    check("t6_nreads", addr_log.size(), 4);
    if (addr_log.size() == 4) begin
      check("t6_lib0", addr_log[1], 32'hFFFF_FFFC);
      check("t6_lib1", addr_log[3], 32'h0000_0000);
    end
    if (lib_log.size() == 2) check("t6_libdata", lib_log[1], mem_word(32'h0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hsid_x_seq.md
Name: hsid_x_seq

Overview:
- Top-level sequencer for the HSpecID-X accelerator; sits between the control/status register block and the MSE datapath plus the memory read port.
- On `start`, walks every band of the captured pixel against every library pixel.
- Issues word reads through a single-outstanding req/gnt/rvalid port and streams band pairs to the MSE unit.
- Tracks the minimum and maximum MSE together with their library indices, and reports idle/ready/done/error back to the register block.

Parameters:
- WORD_WIDTH, 32, data/address width; one band per word.
- HSI_BANDS, 128, maximum bands per pixel. HSI_BANDS_ADDR = $clog2(HSI_BANDS), localparam.
- HSI_LIBRARY_SIZE, 256, maximum library pixels. HSI_LIBRARY_SIZE_ADDR = $clog2(HSI_LIBRARY_SIZE), localparam.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle start pulse
- clear  in  1  one-cycle clear pulse
- library_size  in  HSI_LIBRARY_SIZE_ADDR  number of library pixels
- pixel_bands  in  HSI_BANDS_ADDR  bands per pixel
- captured_pixel_addr  in  WORD_WIDTH  byte base address of the captured pixel
- library_pixel_addr  in  WORD_WIDTH  byte base address of library pixel 0
- idle, ready, done, error  out  1 each  status
- mem_req  out  1  read request
- mem_addr  out  WORD_WIDTH  byte address
- mem_gnt  in  1  request accepted
- mem_rvalid  in  1  read data valid
- mem_rdata  in  WORD_WIDTH  read data
- mem_err  in  1  bus error; sampled together with mem_rvalid
- band_valid  out  1  band pair valid (one-cycle pulse)
- band_cap  out  WORD_WIDTH  captured band value
- band_lib  out  WORD_WIDTH  library band value
- band_last  out  1  last band of the current library pixel
- mse_valid  in  1  MSE result for the current pixel
- mse_value  in  WORD_WIDTH  MSE result
- mse_min_ref, mse_max_ref  out  HSI_LIBRARY_SIZE_ADDR  library index of the min/max MSE
- mse_min_value, mse_max_value  out  WORD_WIDTH  min/max MSE value

Behaviour:

Reset (rst=1 at a clock edge):
- State goes to IDLE.
- All outputs 0 except idle=1 and ready=1.
- Min/max registers are 0.

States:
- IDLE: idle=1, ready=1.
  - start with library_size==0 or pixel_bands==0 -> ERROR.
  - Other start -> RD_CAP. Band counter b=0, pixel counter p=0, lib_addr=library_pixel_addr. done, error and min/max cleared in the same cycle.
- RD_CAP: mem_req=1, mem_addr=captured_pixel_addr+4*b. On mem_gnt -> WAIT_CAP.
- WAIT_CAP: on mem_rvalid, latch cap word -> RD_LIB.
- RD_LIB: mem_req=1, mem_addr=lib_addr. On mem_gnt -> WAIT_LIB.
- WAIT_LIB: on mem_rvalid, latch lib word and do lib_addr+=4 -> PUSH.
- PUSH: band_valid=1 for exactly one cycle, band_last=(b==pixel_bands-1).
  - Not last: b++ -> RD_CAP.
  - Last: b=0 -> WAIT_MSE.
- WAIT_MSE: on mse_valid, update min/max.
  - p==library_size-1 -> DONE.
  - Otherwise p++ -> RD_CAP.
- DONE: done=1, idle=1, ready=1. start behaves as in IDLE.
- ERROR: error=1, idle=1, ready=1. start behaves as in IDLE.

Handshake and addressing rules:
- mem_req is held with mem_addr stable until mem_gnt. No new request is issued before rvalid.
- mem_err=1 with mem_rvalid -> ERROR. min/max keep their partial values.
- Address arithmetic is unsigned modulo 2^WORD_WIDTH, wrap allowed.
- The library address increments linearly, so pixel p starts at library_pixel_addr+4*p*pixel_bands. No multiplier.

Min/max rules:
- First result (p==0) loads both min and max, with ref=0.
- Later results:
  - min updates only if mse_value < min (strict unsigned), so ties keep the earlier index.
  - max updates only if mse_value > max (strict).

Timing:
- Latency per pixel with zero-wait memory (gnt same cycle, rvalid next cycle) is 5*pixel_bands cycles plus the MSE latency plus 1.

Clear and simultaneous events:
- clear in any state -> IDLE next cycle. mem_req drops, done/error cleared, min/max zeroed.
- Outstanding rvalids after a clear are ignored.
- clear has priority over start in the same cycle.
- start is ignored while busy (any state other than IDLE, DONE or ERROR).
- Inputs library_size, pixel_bands and both addresses are sampled only at start.

Decomposition:
- hsid_x_pkg holds:
  - the state enum hsid_x_seq_state_e;
  - the constant WORD_BYTES=4;
  - a struct hsid_x_mse_res_t {value, ref}.
- Sub-module hsid_x_minmax holds the min/max tracker: init/update inputs, strict-compare rules, clear.

Test Plan:
1. Happy path: bands=2, lib=3, zero-wait memory, MSE results 50, 20, 80 -> addresses cap+0, lib+0, cap+4, lib+4, cap+0, lib+8, …; done=1; min=20/ref 1; max=80/ref 2.
2. Ties: results 7, 7, 7 -> min_ref=0, max_ref=0, values 7.
3. Zero configuration: start with pixel_bands=0 -> error=1 next cycle, no mem_req, done=0; a following start with valid config clears error.
4. Stall/error: hold mem_gnt low 5 cycles -> mem_addr stable and mem_req held. Then mem_err on the 3rd read -> ERROR, band_valid count=1.
5. Clear mid-run: at pixel 1 assert clear while a late rvalid arrives -> IDLE next cycle, min/max=0, the rvalid is ignored; start on the same cycle as clear is dropped.
6. Wrap: library_pixel_addr=0xFFFFFFFC, bands=2 -> second library read at 0x00000000.
